// File: rtl/dcache_wb_buffer.sv
// Write-back buffer sitting between the data cache memory port and the
// backing memory. Evicted dirty lines are queued so that the refill read can
// go straight to memory; queued lines are forwarded to matching reads,
// coalesced with matching writes, and drained while the memory side is idle.
module dcache_wb_buffer #(
  parameter int DEPTH  = 2,
  parameter int LINE_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       cache_addr_i,
  input  logic [LINE_W-1:0] cache_data_i,
  input  logic              cache_enable_i,
  input  logic              cache_write_i,
  output logic              cache_ack_o,
  output logic [LINE_W-1:0] cache_data_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic              mem_ack_i,
  input  logic [LINE_W-1:0] mem_data_i,
  output logic              empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RD_MEM, WR_MEM, RESP} state_t;

  state_t            state_q, state_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [26:0]       tag_q  [DEPTH];
  logic [26:0]       tag_d  [DEPTH];
  logic [LINE_W-1:0] line_q [DEPTH];
  logic [LINE_W-1:0] line_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              cache_ack_q, cache_ack_d;
  logic [LINE_W-1:0] cache_data_q, cache_data_d;
  logic              mem_enable_q, mem_enable_d;
  logic              mem_write_q, mem_write_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_data_q, mem_data_d;
  logic              empty_q, empty_d;

  logic [26:0]       req_line;
  logic [DEPTH-1:0]  match;
  logic              hit;
  logic              full;
  logic [PTR_W-1:0]  hit_idx;
  logic              addr_offset_unused;

  assign req_line           = cache_addr_i[31:5];
  assign addr_offset_unused = ^cache_addr_i[4:0];
  assign hit                = |match;
  assign full               = (count_q == CNT_W'(DEPTH));

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Per-entry line-address comparators; only valid entries can match.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match[gi] = valid_q[gi] && (tag_q[gi] == req_line);
    end
  endgenerate

  // Encode the (unique) matching entry into an index.
  always_comb begin
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (match[i]) hit_idx = PTR_W'(i);
    end
  end

  // State register and all datapath flops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      cache_ack_q  <= 1'b0;
      cache_data_q <= '0;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      empty_q      <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i]  <= '0;
        line_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      cache_ack_q  <= cache_ack_d;
      cache_data_q <= cache_data_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      empty_q      <= empty_d;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i]  <= tag_d[i];
        line_q[i] <= line_d[i];
      end
    end
  end

  // Next-state logic: cache requests are only looked at in IDLE, and a
  // pending request always wins over starting a background drain.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cache_enable_i) begin
          if (cache_write_i) state_d = (hit || !full) ? RESP : WR_MEM;
          else               state_d = hit ? RESP : RD_MEM;
        end else if (count_q != '0) begin
          state_d = WR_MEM;
        end
      end
      RD_MEM:  if (mem_ack_i) state_d = RESP;
      WR_MEM:  if (mem_ack_i) state_d = IDLE;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/storage logic: registered next values for ports and FIFO.
  always_comb begin
    valid_d      = valid_q;
    tag_d        = tag_q;
    line_d       = line_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    cache_ack_d  = 1'b0;
    cache_data_d = cache_data_q;
    mem_enable_d = mem_enable_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    case (state_q)
      IDLE: begin
        if (cache_enable_i && cache_write_i && hit) begin
          // Coalesce into the existing entry for this line.
          line_d[hit_idx] = cache_data_i;
          cache_ack_d     = 1'b1;
        end else if (cache_enable_i && cache_write_i && !full) begin
          valid_d[tail_q] = 1'b1;
          tag_d[tail_q]   = req_line;
          line_d[tail_q]  = cache_data_i;
          tail_d          = ptr_inc(tail_q);
          count_d         = count_q + 1'b1;
          cache_ack_d     = 1'b1;
        end else if (cache_enable_i && !cache_write_i && hit) begin
          cache_data_d = line_q[hit_idx];
          cache_ack_d  = 1'b1;
        end else if (cache_enable_i && !cache_write_i) begin
          mem_enable_d = 1'b1;
          mem_write_d  = 1'b0;
          mem_addr_d   = {req_line, 5'b0};
        end else if (count_q != '0) begin
          // Drain the head: idle memory, or a write blocked by a full buffer.
          mem_enable_d = 1'b1;
          mem_write_d  = 1'b1;
          mem_addr_d   = {tag_q[head_q], 5'b0};
          mem_data_d   = line_q[head_q];
        end
      end
      RD_MEM: begin
        if (mem_ack_i) begin
          cache_data_d = mem_data_i;
          cache_ack_d  = 1'b1;
          mem_enable_d = 1'b0;
        end
      end
      WR_MEM: begin
        if (mem_ack_i) begin
          valid_d[head_q] = 1'b0;
          head_d          = ptr_inc(head_q);
          count_d         = count_q - 1'b1;
          mem_enable_d    = 1'b0;
        end
      end
      default: ;
    endcase
    empty_d = (count_d == '0);
  end

  assign cache_ack_o  = cache_ack_q;
  assign cache_data_o = cache_data_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;
  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign empty_o      = empty_q;

endmodule

// File: tb/tb_dcache_wb_buffer.sv
// Directed bench for dcache_wb_buffer with a fixed-latency memory model.
module tb_dcache_wb_buffer;

  localparam int MEM_LAT = 2;
  localparam logic [255:0] D1  = {8{32'h1111_0001}};
  localparam logic [255:0] D2  = {8{32'h2222_0002}};
  localparam logic [255:0] D3  = {8{32'h3333_0003}};
  localparam logic [255:0] ECF = {16{16'hECFA}};

  logic         clk = 1'b0;
  logic         rst_i;
  logic [31:0]  cache_addr_i;
  logic [255:0] cache_data_i;
  logic         cache_enable_i;
  logic         cache_write_i;
  logic         cache_ack_o;
  logic [255:0] cache_data_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic         mem_ack_i = 1'b0;
  logic [255:0] mem_data_i = '0;
  logic         empty_o;

  int checks = 0;
  int passed = 0;

  // memory model state
  logic [255:0] mem [64];
  bit           written [64];
  logic [31:0]  wlog_addr [$];
  logic [255:0] wlog_data [$];
  int           wait_cnt = 0;
  int           m_idx;
  int           en_cycles = 0;
  int           ack_cnt = 0;
  bit           mem_auto = 1'b1;
  bit           stray_req = 1'b0;
  bit           stray_done = 1'b0;

  always #5 clk = ~clk;

  dcache_wb_buffer #(.DEPTH(2), .LINE_W(256)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cache_addr_i(cache_addr_i), .cache_data_i(cache_data_i),
    .cache_enable_i(cache_enable_i), .cache_write_i(cache_write_i),
    .cache_ack_o(cache_ack_o), .cache_data_o(cache_data_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .empty_o(empty_o)
  );

  // Memory responder: acks MEM_LAT+1 negedges after the request is seen.
  always @(negedge clk) begin
    m_idx = int'(mem_addr_o[10:5]);
    if (mem_ack_i) begin
      mem_ack_i = 1'b0;
    end else if (mem_auto && mem_enable_o) begin
      if (wait_cnt == MEM_LAT) begin
        wait_cnt  = 0;
        mem_ack_i = 1'b1;
        if (mem_write_o) begin
          mem[m_idx]     = mem_data_o;
          written[m_idx] = 1'b1;
          wlog_addr.push_back(mem_addr_o);
          wlog_data.push_back(mem_data_o);
        end else begin
          if (written[m_idx])  mem_data_i = mem[m_idx];
          else if (m_idx == 2) mem_data_i = ECF;
          else                 mem_data_i = {8{32'hBEEF_0000 | 32'(m_idx)}};
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
      if (!mem_auto && stray_req && !stray_done) begin
        mem_ack_i  = 1'b1;
        mem_data_i = {8{32'h5A5A_5A5A}};
        stray_done = 1'b1;
      end
    end
    if (mem_enable_o) en_cycles++;
    if (cache_ack_o)  ack_cnt++;
  end

  // Issue one cache request (called at a negedge), wait for the ack.
  task automatic cache_req(input logic wr, input logic [31:0] addr,
                           input logic [255:0] wdata, output int lat,
                           output logic [255:0] rdata);
    cache_enable_i = 1'b1;
    cache_write_i  = wr;
    cache_addr_i   = addr;
    cache_data_i   = wdata;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!cache_ack_o && lat < 100);
    rdata = cache_data_o;
    if (cache_ack_o !== 1'b1) begin
      checks++;
      $display("FAIL req_timeout addr=%h ack=%b required 1", addr, cache_ack_o);
    end
    $display("txn %s addr=%h lat=%0d data=%h", wr ? "WR" : "RD", addr, lat,
             wr ? wdata : rdata);
    @(negedge clk);
    cache_enable_i = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    @(negedge clk);
    while (!(empty_o === 1'b1 && mem_enable_o === 1'b0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(empty_o === 1'b1 && mem_enable_o === 1'b0))
      $display("FAIL drain_done empty=%b mem_enable=%b required 1/0", empty_o, mem_enable_o);
    else passed++;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (cache_ack_o !== 1'b0) $display("FAIL rst_cache_ack got %b exp 0", cache_ack_o); else passed++;
    checks++; if (cache_data_o !== '0) $display("FAIL rst_cache_data got %h exp 0", cache_data_o); else passed++;
    checks++; if (mem_enable_o !== 1'b0) $display("FAIL rst_mem_enable got %b exp 0", mem_enable_o); else passed++;
    checks++; if (mem_write_o !== 1'b0) $display("FAIL rst_mem_write got %b exp 0", mem_write_o); else passed++;
    checks++; if (mem_addr_o !== 32'h0) $display("FAIL rst_mem_addr got %h exp 0", mem_addr_o); else passed++;
    checks++; if (mem_data_o !== '0) $display("FAIL rst_mem_data got %h exp 0", mem_data_o); else passed++;
    checks++; if (empty_o !== 1'b1) $display("FAIL rst_empty got %b exp 1", empty_o); else passed++;
    rst_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_drain();
    int lat; logic [255:0] rd; int wl0;
    wl0 = wlog_addr.size();
    cache_req(1'b1, 32'h0000_0400, D1, lat, rd);
    checks++; if (lat !== 1) $display("FAIL wr_lat got %0d exp 1", lat); else passed++;
    checks++; if (empty_o !== 1'b0) $display("FAIL wr_not_empty got %b exp 0", empty_o); else passed++;
    checks++; if (mem_enable_o !== 1'b0) $display("FAIL wr_no_mem got %b exp 0", mem_enable_o); else passed++;
    wait_empty();
    checks++; if (wlog_addr.size() !== wl0 + 1) $display("FAIL wr_drain_cnt got %0d exp %0d", wlog_addr.size(), wl0 + 1); else passed++;
    if (wlog_addr.size() > wl0) begin
      checks++; if (wlog_addr[wl0] !== 32'h400) $display("FAIL wr_drain_addr got %h exp 400", wlog_addr[wl0]); else passed++;
      checks++; if (wlog_data[wl0] !== D1) $display("FAIL wr_drain_data got %h exp %h", wlog_data[wl0], D1); else passed++;
    end
  endtask

  task automatic test_read_forward();
    int lat; logic [255:0] rd; int en0; int wl0;
    wl0 = wlog_addr.size();
    en0 = en_cycles;
    cache_req(1'b1, 32'h0000_0400, D1, lat, rd);
    cache_req(1'b0, 32'h0000_0400, '0, lat, rd);
    checks++; if (lat !== 2) $display("FAIL fwd_lat got %0d exp 2", lat); else passed++;
    checks++; if (rd !== D1) $display("FAIL fwd_data got %h exp %h", rd, D1); else passed++;
    checks++; if (en_cycles !== en0) $display("FAIL fwd_no_mem got %0d exp %0d", en_cycles, en0); else passed++;
    wait_empty();
    checks++; if (wlog_addr.size() !== wl0 + 1) $display("FAIL fwd_drain_cnt got %0d exp %0d", wlog_addr.size(), wl0 + 1); else passed++;
  endtask

  task automatic test_coalesce();
    int lat; logic [255:0] rd; int wl0;
    wl0 = wlog_addr.size();
    cache_req(1'b1, 32'h0000_0400, D1, lat, rd);
    cache_req(1'b1, 32'h0000_041F, D2, lat, rd);
    checks++; if (lat !== 2) $display("FAIL coal_lat got %0d exp 2", lat); else passed++;
    wait_empty();
    checks++; if (wlog_addr.size() !== wl0 + 1) $display("FAIL coal_cnt got %0d exp %0d", wlog_addr.size(), wl0 + 1); else passed++;
    if (wlog_addr.size() > wl0) begin
      checks++; if (wlog_addr[wl0] !== 32'h400) $display("FAIL coal_addr got %h exp 400", wlog_addr[wl0]); else passed++;
      checks++; if (wlog_data[wl0] !== D2) $display("FAIL coal_data got %h exp %h", wlog_data[wl0], D2); else passed++;
    end
  endtask

  task automatic test_full_stall();
    int lat; logic [255:0] rd; int wl0;
    wl0 = wlog_addr.size();
    cache_req(1'b1, 32'h0000_0000, D1, lat, rd);
    cache_req(1'b1, 32'h0000_0200, D2, lat, rd);
    cache_req(1'b1, 32'h0000_0400, D3, lat, rd);
    checks++; if (lat !== MEM_LAT + 4) $display("FAIL full_lat got %0d exp %0d", lat, MEM_LAT + 4); else passed++;
    checks++; if (wlog_addr.size() !== wl0 + 1) $display("FAIL full_first_cnt got %0d exp %0d", wlog_addr.size(), wl0 + 1); else passed++;
    wait_empty();
    checks++; if (wlog_addr.size() !== wl0 + 3) $display("FAIL full_total_cnt got %0d exp %0d", wlog_addr.size(), wl0 + 3); else passed++;
    if (wlog_addr.size() >= wl0 + 3) begin
      checks++; if (wlog_addr[wl0] !== 32'h000 || wlog_data[wl0] !== D1) $display("FAIL full_drain0 got %h exp 0", wlog_addr[wl0]); else passed++;
      checks++; if (wlog_addr[wl0+1] !== 32'h200 || wlog_data[wl0+1] !== D2) $display("FAIL full_drain1 got %h exp 200", wlog_addr[wl0+1]); else passed++;
      checks++; if (wlog_addr[wl0+2] !== 32'h400 || wlog_data[wl0+2] !== D3) $display("FAIL full_drain2 got %h exp 400", wlog_addr[wl0+2]); else passed++;
    end
  endtask

  task automatic test_read_priority();
    int lat; logic [255:0] rd; int wl0;
    wl0 = wlog_addr.size();
    cache_req(1'b1, 32'h0000_0400, D1, lat, rd);
    cache_req(1'b0, 32'h0000_0040, '0, lat, rd);
    checks++; if (lat !== MEM_LAT + 3) $display("FAIL prio_lat got %0d exp %0d", lat, MEM_LAT + 3); else passed++;
    checks++; if (rd !== ECF) $display("FAIL prio_data got %h exp %h", rd, ECF); else passed++;
    checks++; if (wlog_addr.size() !== wl0) $display("FAIL prio_no_drain_yet got %0d exp %0d", wlog_addr.size(), wl0); else passed++;
    wait_empty();
    checks++; if (wlog_addr.size() !== wl0 + 1) $display("FAIL prio_drain_cnt got %0d exp %0d", wlog_addr.size(), wl0 + 1); else passed++;
    if (wlog_addr.size() > wl0) begin
      checks++; if (wlog_data[wl0] !== D1 || wlog_addr[wl0] !== 32'h400) $display("FAIL prio_drain got %h exp 400", wlog_addr[wl0]); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [255:0] rd; int en0; int ack0; int wl0;
    mem_auto = 1'b0;
    cache_req(1'b1, 32'h0000_0400, D3, lat, rd);
    cache_enable_i = 1'b1; cache_write_i = 1'b0; cache_addr_i = 32'h0000_0060;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (mem_enable_o !== 1'b1 || mem_write_o !== 1'b0) $display("FAIL rdmem_req en=%b wr=%b exp 1/0", mem_enable_o, mem_write_o); else passed++;
    checks++; if (mem_addr_o !== 32'h60) $display("FAIL rdmem_addr got %h exp 60", mem_addr_o); else passed++;
    @(negedge clk);
    rst_i = 1'b1; cache_enable_i = 1'b0;
    @(posedge clk); #1;
    checks++; if (mem_enable_o !== 1'b0) $display("FAIL midrst_enable got %b exp 0", mem_enable_o); else passed++;
    checks++; if (empty_o !== 1'b1) $display("FAIL midrst_empty got %b exp 1", empty_o); else passed++;
    @(negedge clk);
    rst_i = 1'b0;
    en0 = en_cycles; ack0 = ack_cnt; wl0 = wlog_addr.size();
    stray_req = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (ack_cnt !== ack0) $display("FAIL stray_ack got %0d exp %0d", ack_cnt, ack0); else passed++;
    checks++; if (en_cycles !== en0) $display("FAIL discarded_no_drain got %0d exp %0d", en_cycles, en0); else passed++;
    checks++; if (wlog_addr.size() !== wl0) $display("FAIL discarded_no_write got %0d exp %0d", wlog_addr.size(), wl0); else passed++;
    checks++; if (empty_o !== 1'b1) $display("FAIL post_rst_empty got %b exp 1", empty_o); else passed++;
    mem_auto = 1'b1;
  endtask

  initial begin
    rst_i = 1'b1;
    cache_enable_i = 1'b0;
    cache_write_i = 1'b0;
    cache_addr_i = '0;
    cache_data_i = '0;
    test_reset();
    test_write_drain();
    test_read_forward();
    test_coalesce();
    test_full_stall();
    test_read_priority();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout time=%0t limit=200000", $time);
    $fatal(1, "timeout");
  end

endmodule
